core_bus_arbiter: RTL and testbench
===================================

Name: core_bus_arbiter

Overview:
- Two-master to one-slave arbiter that sits directly downstream of the core's instruction and data bus masters.
- Merges both onto a single naive-bus slave port toward the SoC bus router.
- Arbitration is per cycle: the data master has priority, bounded by an anti-starvation counter for the instruction master.
- Read responses return one cycle after grant; the block steers them to the master that was granted.

Parameters:
- STARVE_LIMIT, 4, consecutive denied requesting cycles of the instr master after which the instr master wins the next arbitration (1..15).
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- m0_rd_req  in  1  instr master read request
- m0_rd_addr  in  AW  instr master read address
- m0_rd_gnt  out  1  instr master read grant
- m0_rd_data  out  DW  instr master read data, valid cycle after grant
- m1_rd_req  in  1  data master read request
- m1_rd_addr  in  AW  data master read address
- m1_rd_gnt  out  1  data master read grant
- m1_rd_data  out  DW  data master read data, valid cycle after grant
- m1_wr_req  in  1  data master write request
- m1_wr_addr  in  AW  data master write address
- m1_wr_data  in  DW  data master write data
- m1_wr_be  in  4  data master byte enables
- m1_wr_gnt  out  1  data master write grant
- s_rd_req  out  1  slave read request
- s_rd_addr  out  AW  slave read address
- s_rd_gnt  in  1  slave read grant
- s_rd_data  in  DW  slave read data, valid cycle after s_rd_gnt
- s_wr_req  out  1  slave write request
- s_wr_addr  out  AW  slave write address
- s_wr_data  out  DW  slave write data
- s_wr_be  out  4  slave byte enables
- s_wr_gnt  in  1  slave write grant

Behaviour:
- Protocol:
  - A master holds req/addr/data stable until it sees its gnt in the same cycle.
  - A master never asserts rd_req and wr_req together.
  - A transfer completes in a cycle where req and gnt are both high.
- Requests: m0_any = m0_rd_req; m1_any = m1_rd_req | m1_wr_req.
- Selection (combinational, from registered state):
  - sel = M1 if m1_any and not starved.
  - sel = M0 if m0_any and (starved or not m1_any).
  - Otherwise sel = NONE.
  - starved = (starve_cnt >= STARVE_LIMIT).
- Forwarding: only the selected master's req/addr/data/be drive the s_* outputs. With sel = NONE, all s_* requests are 0 and addr/data/be are 0.
- Grant routing:
  - s_rd_gnt / s_wr_gnt go only to the selected master's matching gnt.
  - Non-selected gnts are 0.
  - A gnt is never asserted without the matching req.
- starve_cnt (4-bit register):
  - Increments, saturating at 15, when m0_rd_req is high and m0_rd_gnt is low.
  - Clears when m0_rd_gnt is high or m0_rd_req is low.
- Response steering:
  - Register rsp_vld <= s_rd_req & s_rd_gnt and rsp_sel <= sel.
  - In the next cycle, the master named by rsp_sel receives s_rd_data on its rd_data. The other master's rd_data is 0.
  - rd_data is 0 whenever rsp_vld is 0.
- Back-to-back:
  - A new grant may occur in the same cycle that the previous read's data is returned.
  - rsp_sel/rsp_vld update every cycle, so consecutive reads to alternating masters are each steered correctly.
- Slave stall: s_rd_gnt = 0 keeps the request pending. Selection may change next cycle (data master arrives); the abandoned m0 request stays pending with no side effects.
- Reset:
  - While rst_n is low: starve_cnt = 0, rsp_vld = 0, rsp_sel = M0.
  - All gnt outputs and all s_*_req outputs are forced to 0.
  - All rd_data outputs are 0.
  - Reset asserted mid-transfer drops the in-flight response; no data is delivered after reset.

Decomposition:
- Shared package core_bus_pkg: enum bus_sel_t {SEL_NONE, SEL_M0, SEL_M1} and the protocol widths.
- No sub-module. Selection logic, counter and response register stay in one file (roughly 150-200 lines).

Test Plan:
- m0 read 0x0000_0100 alone, slave grants at once, returns 0xDEAD_BEEF next cycle -> m0_rd_gnt = 1 in cycle 0, m0_rd_data = 0xDEAD_BEEF in cycle 1, m1_rd_data = 0.
- m0 and m1 reads together, slave always grants -> m1 granted first; m0 granted in the following cycle; each master receives its own distinct data.
- m1 write requests continuous, m0 read pending, STARVE_LIMIT = 4 -> m0 denied 4 cycles then granted in cycle 4; starve_cnt returns to 0.
- Slave holds s_rd_gnt = 0 for 3 cycles on an m0 read -> no gnt or rd_data during the stall; grant and data follow normally once s_rd_gnt rises.
- Alternating back-to-back reads m1, m0, m1 with data 1, 2, 3 -> m1_rd_data = 1, m0_rd_data = 2, m1_rd_data = 3 in consecutive cycles.
- rst_n pulsed low in the cycle after a granted read -> all rd_data = 0, rsp_vld = 0, starve_cnt = 0; normal arbitration resumes after release.

Source files
------------

// File: rtl/core_bus_pkg.sv
// Shared types and protocol widths for the core bus arbiter.
package core_bus_pkg;

  localparam int unsigned BeW  = 4;
  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_M0,
    SEL_M1
  } bus_sel_t;

endpackage

// File: rtl/core_bus_arbiter.sv
// Two-master (instr m0, data m1) to one-slave naive-bus arbiter. The data master has
// priority, bounded by an anti-starvation counter for the instr master.
module core_bus_arbiter
  import core_bus_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32
) (
  input  logic           clk,
  input  logic           rst_n,

  input  logic           m0_rd_req,
  input  logic [AW-1:0]  m0_rd_addr,
  output logic           m0_rd_gnt,
  output logic [DW-1:0]  m0_rd_data,

  input  logic           m1_rd_req,
  input  logic [AW-1:0]  m1_rd_addr,
  output logic           m1_rd_gnt,
  output logic [DW-1:0]  m1_rd_data,
  input  logic           m1_wr_req,
  input  logic [AW-1:0]  m1_wr_addr,
  input  logic [DW-1:0]  m1_wr_data,
  input  logic [BeW-1:0] m1_wr_be,
  output logic           m1_wr_gnt,

  output logic           s_rd_req,
  output logic [AW-1:0]  s_rd_addr,
  input  logic           s_rd_gnt,
  input  logic [DW-1:0]  s_rd_data,
  output logic           s_wr_req,
  output logic [AW-1:0]  s_wr_addr,
  output logic [DW-1:0]  s_wr_data,
  output logic [BeW-1:0] s_wr_be,
  input  logic           s_wr_gnt
);

  localparam logic [CntW-1:0] CntMax = '1;

  logic [CntW-1:0] starve_q, starve_d;
  logic            rsp_vld_q, rsp_vld_d;
  bus_sel_t        rsp_sel_q;
  bus_sel_t        sel;
  logic            starved;
  logic            m0_any, m1_any;

  assign m0_any  = m0_rd_req;
  assign m1_any  = m1_rd_req | m1_wr_req;
  assign starved = (32'(starve_q) >= STARVE_LIMIT);

  always_comb begin
    sel = SEL_NONE;
    if (m1_any && !starved) begin
      sel = SEL_M1;
    end else if (m0_any && (starved || !m1_any)) begin
      sel = SEL_M0;
    end
  end

  // Slave-side forwarding; requests are held off while in reset.
  always_comb begin
    s_rd_req  = 1'b0;
    s_rd_addr = '0;
    s_wr_req  = 1'b0;
    s_wr_addr = '0;
    s_wr_data = '0;
    s_wr_be   = '0;
    unique case (sel)
      SEL_M0: begin
        s_rd_req  = m0_rd_req & rst_n;
        s_rd_addr = m0_rd_addr;
      end
      SEL_M1: begin
        s_rd_req  = m1_rd_req & rst_n;
        s_rd_addr = m1_rd_addr;
        s_wr_req  = m1_wr_req & rst_n;
        s_wr_addr = m1_wr_addr;
        s_wr_data = m1_wr_data;
        s_wr_be   = m1_wr_be;
      end
      default: ;
    endcase
  end

  // Grants follow the forwarded request, so no gnt appears without its req.
  always_comb begin
    m0_rd_gnt = 1'b0;
    m1_rd_gnt = 1'b0;
    m1_wr_gnt = 1'b0;
    unique case (sel)
      SEL_M0: m0_rd_gnt = s_rd_req & s_rd_gnt;
      SEL_M1: begin
        m1_rd_gnt = s_rd_req & s_rd_gnt;
        m1_wr_gnt = s_wr_req & s_wr_gnt;
      end
      default: ;
    endcase
  end

  always_comb begin
    starve_d = '0;
    if (m0_rd_req && !m0_rd_gnt) begin
      starve_d = (starve_q == CntMax) ? starve_q : starve_q + 1'b1;
    end
  end

  assign rsp_vld_d = s_rd_req & s_rd_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q  <= '0;
      rsp_vld_q <= 1'b0;
      rsp_sel_q <= SEL_M0;
    end else begin
      starve_q  <= starve_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_sel_q <= sel;
    end
  end

  // Read data is steered to whichever master was granted in the previous cycle.
  always_comb begin
    m0_rd_data = '0;
    m1_rd_data = '0;
    if (rsp_vld_q) begin
      unique case (rsp_sel_q)
        SEL_M0:  m0_rd_data = s_rd_data;
        SEL_M1:  m1_rd_data = s_rd_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed bench for core_bus_arbiter with a one-cycle response scoreboard.
module tb_core_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic        m0_rd_req;
  logic [31:0] m0_rd_addr;
  logic        m0_rd_gnt;
  logic [31:0] m0_rd_data;
  logic        m1_rd_req;
  logic [31:0] m1_rd_addr;
  logic        m1_rd_gnt;
  logic [31:0] m1_rd_data;
  logic        m1_wr_req;
  logic [31:0] m1_wr_addr;
  logic [31:0] m1_wr_data;
  logic [3:0]  m1_wr_be;
  logic        m1_wr_gnt;
  logic        s_rd_req;
  logic [31:0] s_rd_addr;
  logic        s_rd_gnt;
  logic [31:0] s_rd_data;
  logic        s_wr_req;
  logic [31:0] s_wr_addr;
  logic [31:0] s_wr_data;
  logic [3:0]  s_wr_be;
  logic        s_wr_gnt;

  typedef struct packed {
    logic [31:0] m0;
    logic [31:0] m1;
  } rsp_t;

  rsp_t sb[$];
  int   checks;
  int   failures;

  core_bus_arbiter #(
    .STARVE_LIMIT(4),
    .AW          (32),
    .DW          (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0_rd_req (m0_rd_req),
    .m0_rd_addr(m0_rd_addr),
    .m0_rd_gnt (m0_rd_gnt),
    .m0_rd_data(m0_rd_data),
    .m1_rd_req (m1_rd_req),
    .m1_rd_addr(m1_rd_addr),
    .m1_rd_gnt (m1_rd_gnt),
    .m1_rd_data(m1_rd_data),
    .m1_wr_req (m1_wr_req),
    .m1_wr_addr(m1_wr_addr),
    .m1_wr_data(m1_wr_data),
    .m1_wr_be  (m1_wr_be),
    .m1_wr_gnt (m1_wr_gnt),
    .s_rd_req  (s_rd_req),
    .s_rd_addr (s_rd_addr),
    .s_rd_gnt  (s_rd_gnt),
    .s_rd_data (s_rd_data),
    .s_wr_req  (s_wr_req),
    .s_wr_addr (s_wr_addr),
    .s_wr_data (s_wr_data),
    .s_wr_be   (s_wr_be),
    .s_wr_gnt  (s_wr_gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Slave memory image: fixed words for the directed addresses, a pattern elsewhere.
  function automatic logic [31:0] data_of(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'hDEAD_BEEF;
      32'h0000_0001: return 32'h0000_0001;
      32'h0000_0002: return 32'h0000_0002;
      32'h0000_0003: return 32'h0000_0003;
      default:       return {~a[15:0], a[15:0]};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle: inputs are already driven; check at negedge, then advance the slave.
  task automatic cyc(input logic e_srd, input logic e_m0g, input logic e_m1rg,
                     input logic e_m1wg);
    rsp_t        exp;
    rsp_t        nxt;
    logic        xfer;
    logic [31:0] pend;
    @(negedge clk);
    exp = sb.pop_front();
    chk("m0_rd_data", 64'(m0_rd_data), 64'(exp.m0));
    chk("m1_rd_data", 64'(m1_rd_data), 64'(exp.m1));
    chk("m0_rd_gnt", 64'(m0_rd_gnt), 64'(e_m0g));
    chk("m1_rd_gnt", 64'(m1_rd_gnt), 64'(e_m1rg));
    chk("m1_wr_gnt", 64'(m1_wr_gnt), 64'(e_m1wg));
    chk("s_rd_req", 64'(s_rd_req), 64'(e_srd));
    if (e_m1wg) begin
      chk("s_wr_addr", 64'(s_wr_addr), 64'(m1_wr_addr));
      chk("s_wr_data", 64'(s_wr_data), 64'(m1_wr_data));
      chk("s_wr_be", 64'(s_wr_be), 64'(m1_wr_be));
    end
    nxt.m0 = e_m0g ? data_of(m0_rd_addr) : 32'h0;
    nxt.m1 = e_m1rg ? data_of(m1_rd_addr) : 32'h0;
    sb.push_back(nxt);
    xfer = s_rd_req & s_rd_gnt;
    pend = data_of(s_rd_addr);
    @(posedge clk);
    #1;
    s_rd_data = xfer ? pend : 32'h0;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    m0_rd_req  = 1'b1;
    m0_rd_addr = 32'h0000_0100;
    m1_rd_req  = 1'b1;
    m1_rd_addr = 32'h0000_0300;
    m1_wr_req  = 1'b0;
    m1_wr_addr = 32'h0;
    m1_wr_data = 32'h0;
    m1_wr_be   = 4'h0;
    s_rd_gnt   = 1'b1;
    s_wr_gnt   = 1'b1;
    s_rd_data  = 32'h0;
    sb.push_back('0);

    // Reset with both masters requesting: nothing granted or forwarded.
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_starve", 64'(dut.starve_q), 64'd0);
    chk("rst_rsp_vld", 64'(dut.rsp_vld_q), 64'd0);
    rst_n     = 1'b1;

    // Lone m0 read of 0x100.
    m1_rd_req = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    m0_rd_req = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Simultaneous reads: m1 first, then m0.
    m0_rd_req  = 1'b1;
    m0_rd_addr = 32'h0000_0200;
    m1_rd_req  = 1'b1;
    m1_rd_addr = 32'h0000_0300;
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    m1_rd_req  = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    m0_rd_req  = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Continuous m1 writes starve m0 for exactly four cycles.
    m0_rd_req  = 1'b1;
    m0_rd_addr = 32'h0000_0400;
    m1_wr_req  = 1'b1;
    m1_wr_addr = 32'h0000_8000;
    for (int i = 0; i < 4; i++) begin
      m1_wr_data = 32'hC0DE_0000 + 32'(i);
      m1_wr_be   = 4'(i + 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
    end
    chk("starve_at_limit", 64'(dut.starve_q), 64'd4);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("starve_clr", 64'(dut.starve_q), 64'd0);
    m0_rd_req  = 1'b0;
    m1_wr_data = 32'h5A5A_A5A5;
    m1_wr_be   = 4'hF;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    m1_wr_req  = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Slave stalls an m0 read for three cycles.
    m0_rd_req  = 1'b1;
    m0_rd_addr = 32'h0000_0500;
    s_rd_gnt   = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    s_rd_gnt   = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    m0_rd_req  = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Alternating back-to-back reads m1, m0, m1 returning 1, 2, 3.
    m0_rd_req  = 1'b1;
    m0_rd_addr = 32'h0000_0002;
    m1_rd_req  = 1'b1;
    m1_rd_addr = 32'h0000_0001;
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    m1_rd_req  = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    m0_rd_req  = 1'b0;
    m1_rd_req  = 1'b1;
    m1_rd_addr = 32'h0000_0003;
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    m1_rd_req  = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the cycle after a granted read drops the response.
    m0_rd_req  = 1'b1;
    m0_rd_addr = 32'h0000_0600;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    rst_n      = 1'b0;
    sb.delete();
    sb.push_back('0);
    #1;
    chk("rst_mid_rsp_vld", 64'(dut.rsp_vld_q), 64'd0);
    chk("rst_mid_starve", 64'(dut.starve_q), 64'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_hold_starve", 64'(dut.starve_q), 64'd0);
    rst_n      = 1'b1;
    m0_rd_addr = 32'h0000_0700;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    m0_rd_req  = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
